// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: datapath <-> multiply/divide unit handshake and HI/LO access bundle.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] srca, srcb, mt_wdata, hi, lo;
  logic mthi_we, mtlo_we, mf_req, busy, stall, done, divz;
  modport master (
    output start, op, srca, srcb, mthi_we, mtlo_we, mt_wdata, mf_req,
    input busy, stall, done, divz, hi, lo
  );
  modport slave (
    input start, op, srca, srcb, mthi_we, mtlo_we, mt_wdata, mf_req,
    output busy, stall, done, divz, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: one-bit-per-cycle MULT/MULTU/DIV/DIVU with HI/LO; MULDIV_EARLY_OUT_EN ends multiplies early.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic reset,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic div_op, sq, sr;
  logic [2*WIDTH-1:0] acc, ma, prod;
  logic [WIDTH-1:0] mb, abs_a, abs_b, quo_fix, rem_fix;
  logic [WIDTH:0] diff;
  logic sa, sb, last;
  // Divide keeps {remainder, dividend/quotient} in acc; multiply accumulates into acc.
  always_comb begin
    sa = ~bus.op[0] & bus.srca[WIDTH-1];
    sb = ~bus.op[0] & bus.srcb[WIDTH-1];
    abs_a = sa ? -bus.srca : bus.srca;
    abs_b = sb ? -bus.srcb : bus.srcb;
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
    prod = sq ? -acc : acc;
    quo_fix = sq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix = sr ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
    last = div_op ? cnt == CNT_W'(WIDTH-1) : (mb >> 1) == '0;
`else
    last = cnt == CNT_W'(WIDTH-1);
`endif
  end
  assign bus.stall = bus.busy & (bus.mf_req | bus.start | bus.mthi_we | bus.mtlo_we);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.divz <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            bus.busy <= 1'b1;
            bus.divz <= 1'b0;
            cnt <= '0;
            div_op <= bus.op[1];
            sq <= sa ^ sb;
            sr <= sa;
            ma <= {{WIDTH{1'b0}}, abs_a};
            mb <= abs_b;
            acc <= bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
          end else begin
            if (bus.mthi_we) bus.hi <= bus.mt_wdata;
            if (bus.mtlo_we) bus.lo <= bus.mt_wdata;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (div_op) begin
            acc <= diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= acc + (mb[0] ? ma : '0);
            ma <= ma << 1;
            mb <= mb >> 1;
          end
          if (last) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          {bus.hi, bus.lo} <= div_op ? {rem_fix, quo_fix} : prod;
          bus.divz <= div_op && mb == '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random MULT/DIV checks against an arithmetic reference model.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  muldiv_sequencer_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint xa, xb;
    xa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    xb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!op[1]) return 64'(xa * xb);
    if (b == 0) return {a, (!op[0] && a[31]) ? 32'd1 : 32'hFFFFFFFF};
    return {32'(xa % xb), 32'(xa / xb)};
  endfunction
  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] m;
    int n;
    if (op[1]) return 32;
    m = (!op[0] && b[31]) ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return 32'($urandom_range(0, 300));
      default: return 32'($urandom());
    endcase
  endfunction
  // mf/mt raise mf_req or MTLO 0x1234 from cycle 5 of the operation onward.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit mf, input bit mt);
    logic [63:0] exp;
    int c, n;
    bit busy_ok, stall_ok;
    exp = ref_res(op, a, b);
    n = ref_lat(op, b);
    @(negedge clk);
    bus.op = op;
    bus.srca = a;
    bus.srcb = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    busy_ok = bus.busy === 1'b1;
    stall_ok = 1'b1;
    chk("divz_cleared", 64'(bus.divz), 64'd0);
    while (bus.done !== 1'b1 && c < 200) begin
      if (c == 5) begin
        bus.mf_req = mf;
        if (mt) begin
          bus.mtlo_we = 1'b1;
          bus.mt_wdata = 32'h1234;
        end
      end
      @(negedge clk);
      c++;
      if (bus.done !== 1'b1) begin
        busy_ok &= bus.busy === 1'b1;
        if (c > 5 && (mf || mt)) stall_ok &= bus.stall === 1'b1;
      end
    end
    chk("latency", 64'(c), 64'(n + 2));
    chk("busy_during", 64'(busy_ok), 64'd1);
    chk("busy_done", 64'(bus.busy), 64'd0);
    chk("hi", 64'(bus.hi), 64'(exp[63:32]));
    chk("lo", 64'(bus.lo), 64'(exp[31:0]));
    chk("divz", 64'(bus.divz), 64'(op[1] && b == 0));
    if (mf || mt) begin
      chk("stall_busy", 64'(stall_ok), 64'd1);
      chk("stall_done", 64'(bus.stall), 64'd0);
    end
    @(negedge clk);
    chk("done_pulse", 64'(bus.done), 64'd0);
    if (mt) chk("mtlo_after", 64'(bus.lo), 64'h1234);
    bus.mf_req = 1'b0;
    bus.mtlo_we = 1'b0;
  endtask
  initial begin
    int c;
    bit seen;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.srca = '0;
    bus.srcb = '0;
    bus.mthi_we = 1'b0;
    bus.mtlo_we = 1'b0;
    bus.mt_wdata = '0;
    bus.mf_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_divz", 64'(bus.divz), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    reset = 1'b0;
    bus.mthi_we = 1'b1;
    bus.mtlo_we = 1'b1;
    bus.mt_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    chk("mt_both", {bus.hi, bus.lo}, 64'hA5A5_5A5A_A5A5_5A5A);
    bus.mthi_we = 1'b0;
    bus.mt_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("mtlo_only", {bus.hi, bus.lo}, 64'hA5A5_5A5A_0BAD_F00D);
    bus.mtlo_we = 1'b0;
    run_op(2'b01, 32'd123, 32'd456, 1'b0, 1'b0);
    chk("multu_lo_const", 64'(bus.lo), 64'h0000_DB18);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
    run_op(2'b11, 32'd55, 32'd0, 1'b0, 1'b0);
    chk("divz_sticky", 64'(bus.divz), 64'd1);
    run_op(2'b00, 32'd7, 32'd0, 1'b1, 1'b0);
    run_op(2'b01, 32'd9, 32'd11, 1'b0, 1'b1);
    bus.op = 2'b01;
    bus.srca = 32'd3;
    bus.srcb = 32'd4;
    bus.start = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.done !== 1'b1 && c < 200);
    chk("held_first_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    chk("held_restart_busy", 64'(bus.busy), 64'd1);
    chk("held_restart_stall", 64'(bus.stall), 64'd1);
    bus.start = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.done !== 1'b1 && c < 200);
    chk("held_second_lo", 64'(bus.lo), 64'd12);
    @(negedge clk);
    bus.op = 2'b01;
    bus.srca = 32'd123;
    bus.srcb = 32'd456;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.done === 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    run_op(2'b01, 32'd123, 32'd456, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
